nes_controller_responder: RTL

//  Device-side end of the NES controller serial link: emulates the 4021-style pad.

---
 rtl/nes_controller_responder_if.sv | 40 ++++
 rtl/nes_controller_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nes_controller_responder_if.sv
// Bundle of host-link and status signals for the NES pad responder.
//
// Signals:
//   latch_in   host latch line, asynchronous, active-high
//   pulse_in   host serial clock, asynchronous, shift on rising edge
//   buttons    button vector, 1 = pressed, synchronous to clk
//   data_out   serial data to host, active-low (0 = pressed)
//   frame_done one-cycle strobe when the last button bit has been shifted
//   busy       1 while loading or shifting
//   bit_idx    index of the bit currently on data_out (0..NUM_BITS)
//   dbg_state  current FSM state, for checkers and bring-up
//
// Handshake: there is no valid/ready pair. The host owns the transfer: a high
// latch_in captures the buttons (the pad presents bit 0); each rising edge of
// pulse_in advances to the next bit. The pad never stalls the host.
//
// Modports: master = host side (drives latch/pulse/buttons),
//           slave  = pad responder (drives data_out and status).
interface nes_controller_responder_if #(
    parameter int NUM_BITS = 8
);
    logic                latch_in;
    logic                pulse_in;
    logic [NUM_BITS-1:0] buttons;
    logic                data_out;
    logic                frame_done;
    logic                busy;
    logic [3:0]          bit_idx;
    logic [1:0]          dbg_state;

    modport master (
        output latch_in, pulse_in, buttons,
        input  data_out, frame_done, busy, bit_idx, dbg_state
    );

    modport slave (
        input  latch_in, pulse_in, buttons,
        output data_out, frame_done, busy, bit_idx, dbg_state
    );
endinterface

// File: rtl/nes_controller_responder.sv
// Device-side end of the NES controller serial link (4021-style pad stand-in).
// Captures the button vector while the host holds latch high, then shifts it
// out active-low, one bit per rising edge of the host's pulse line.
//
// Ports:
//   clk   system clock
//   nrst  asynchronous active-low reset
//   bus   nes_controller_responder_if.slave (host lines, buttons, data/status)
module nes_controller_responder #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          NUM_BITS       = 8,
    parameter logic        FILL_BIT       = 1'b1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                          clk,
    input  logic                          nrst,
    nes_controller_responder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_BITS - 1);
    localparam logic [3:0]  FULL_IDX  = 4'(NUM_BITS);
    localparam logic [15:0] TIMER_END = TIMEOUT_CYCLES - 16'd1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_BITS-1:0]   r_shreg;
    logic [NUM_BITS-1:0]   w_shreg_nxt;
    logic [3:0]            r_bit_idx;
    logic [3:0]            w_bit_idx_nxt;
    logic [15:0]           r_timer;
    logic [15:0]           w_timer_nxt;
    logic                  r_data_out;
    logic                  w_data_out_nxt;
    logic                  r_frame_done;
    logic                  w_frame_done_nxt;

    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_pulse_sync;
    logic                   r_latch_dly;
    logic                   r_pulse_dly;
    logic                   w_latch_s;
    logic                   w_latch_fall;
    logic                   w_pulse_rise;

    // Synchronizers plus one delay flop each for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_latch_sync <= '0;
            r_pulse_sync <= '0;
            r_latch_dly  <= 1'b0;
            r_pulse_dly  <= 1'b0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], bus.latch_in};
            r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], bus.pulse_in};
            r_latch_dly  <= r_latch_sync[SYNC_STAGES-1];
            r_pulse_dly  <= r_pulse_sync[SYNC_STAGES-1];
        end
    end

    assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
    assign w_latch_fall = ~w_latch_s & r_latch_dly;
    assign w_pulse_rise = r_pulse_sync[SYNC_STAGES-1] & ~r_pulse_dly;

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_idx    <= 4'd0;
            r_timer      <= 16'd0;
            r_data_out   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_timer      <= w_timer_nxt;
            r_data_out   <= w_data_out_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Next-state and next-datapath logic. Latch is checked first so it
    // overrides pulse edges and the timeout from any state.
    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_bit_idx_nxt    = r_bit_idx;
        w_timer_nxt      = r_timer;
        w_data_out_nxt   = r_data_out;
        w_frame_done_nxt = 1'b0;

        if (w_latch_s) begin
            w_state_nxt    = ST_LOAD;
            w_shreg_nxt    = bus.buttons;
            w_bit_idx_nxt  = 4'd0;
            w_timer_nxt    = 16'd0;
            w_data_out_nxt = ~bus.buttons[0];
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_data_out_nxt = 1'b1;
                    w_bit_idx_nxt  = 4'd0;
                    w_timer_nxt    = 16'd0;
                end
                ST_LOAD: begin
                    if (w_latch_fall) begin
                        w_state_nxt = ST_SHIFT;
                        w_timer_nxt = 16'd0;
                    end
                end
                ST_SHIFT: begin
                    if (w_pulse_rise) begin
                        w_shreg_nxt = {FILL_BIT, r_shreg[NUM_BITS-1:1]};
                        w_timer_nxt = 16'd0;
                        if (r_bit_idx == LAST_IDX) begin
                            w_state_nxt      = ST_DONE;
                            w_bit_idx_nxt    = FULL_IDX;
                            w_frame_done_nxt = 1'b1;
                            w_data_out_nxt   = ~FILL_BIT;
                        end else begin
                            w_bit_idx_nxt  = r_bit_idx + 4'd1;
                            // shreg[1] becomes the new bit 0 after this shift.
                            w_data_out_nxt = ~r_shreg[1];
                        end
                    end else if (r_timer == TIMER_END) begin
                        w_state_nxt    = ST_IDLE;
                        w_data_out_nxt = 1'b1;
                        w_bit_idx_nxt  = 4'd0;
                        w_timer_nxt    = 16'd0;
                    end else begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (w_pulse_rise) begin
                        // Overclocking past the frame keeps presenting fill.
                        w_shreg_nxt    = {FILL_BIT, r_shreg[NUM_BITS-1:1]};
                        w_timer_nxt    = 16'd0;
                        w_bit_idx_nxt  = FULL_IDX;
                        w_data_out_nxt = ~FILL_BIT;
                    end else if (r_timer == TIMER_END) begin
                        w_state_nxt    = ST_IDLE;
                        w_data_out_nxt = 1'b1;
                        w_bit_idx_nxt  = 4'd0;
                        w_timer_nxt    = 16'd0;
                    end else begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.frame_done = r_frame_done;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.busy       = (r_state == ST_LOAD) | (r_state == ST_SHIFT);
    assign bus.dbg_state  = r_state;

endmodule
